// File: rtl/clb_cfg_pkg.sv
// Shared constants for the CLB configuration loader and the CLB wrapper:
// word width, preamble, field map, reset value and loader states.
package clb_cfg_pkg;

  localparam int CFG_W = 37;
  localparam logic [3:0] PREAMBLE = 4'b0010;
  localparam int FRAME_W = 4 + CFG_W + 1;

  localparam int MUX_W     = 2;
  localparam int MUX2_LSB  = 35;
  localparam int MUX3_LSB  = 33;
  localparam int MUX4_LSB  = 31;
  localparam int MUX5_LSB  = 29;
  localparam int MUX6_LSB  = 27;
  localparam int MEM_LSB   = 11;
  localparam int MEM_W     = 16;
  localparam int COMBO_LSB = 9;
  localparam int COMBO_W   = 2;
  localparam int O2M_LSB   = 3;
  localparam int O2M_W     = 6;
  localparam int DQ_LSB    = 1;
  localparam int DQ_W      = 2;
  localparam int FOL_LSB   = 0;

  localparam logic [CFG_W-1:0] CFG_DEFAULT = {
    2'b10, 2'b10, 2'b10,
    2'b00, 2'b00,
    16'h0116,
    2'b00,
    6'b000111,
    2'b00,
    1'b0
  };

  // Index of the last data bit; counter values at or above it
  // close the data phase.
  localparam logic [5:0] LAST_BIT = 6'd36;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PARITY,
    PASS,
    ERROR
  } state_t;

endpackage

// File: rtl/clb_cfg_loader.sv
// Bit-serial CLB configuration loader with preamble/parity check and
// daisy-chain pass-through. Ports: K, rst_n, PROG, DIN/DIN_VALID in;
// CFG/CFG_VALID, DONE, ERR, DOUT/DOUT_VALID out (all registered).
module clb_cfg_loader
  import clb_cfg_pkg::*;
(
  input  logic             K,
  input  logic             rst_n,
  input  logic             PROG,
  input  logic             DIN,
  input  logic             DIN_VALID,
  output logic [CFG_W-1:0] CFG,
  output logic             CFG_VALID,
  output logic             DONE,
  output logic             ERR,
  output logic             DOUT,
  output logic             DOUT_VALID
);

  state_t           state, state_n;
  logic [3:0]       win, win_n;
  logic [3:0]       win_shift;
  logic [CFG_W-1:0] shadow, shadow_n;
  logic [5:0]       cnt, cnt_n;
  logic             par, par_n;
  logic [CFG_W-1:0] cfg_n;
  logic             cfg_valid_n;
  logic             done_n;
  logic             err_n;
  logic             dout_n;
  logic             dout_valid_n;

  assign win_shift = {win[2:0], DIN};

  always_ff @(posedge K or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= '0;
      shadow     <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      CFG        <= CFG_DEFAULT;
      CFG_VALID  <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      DOUT       <= 1'b1;
      DOUT_VALID <= 1'b0;
    end else begin
      state      <= state_n;
      win        <= win_n;
      shadow     <= shadow_n;
      cnt        <= cnt_n;
      par        <= par_n;
      CFG        <= cfg_n;
      CFG_VALID  <= cfg_valid_n;
      DONE       <= done_n;
      ERR        <= err_n;
      DOUT       <= dout_n;
      DOUT_VALID <= dout_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    win_n        = win;
    shadow_n     = shadow;
    cnt_n        = cnt;
    par_n        = par;
    cfg_n        = CFG;
    cfg_valid_n  = 1'b0;
    done_n       = DONE;
    err_n        = ERR;
    dout_n       = DOUT;
    dout_valid_n = 1'b0;

    if (PROG) begin
      // Restart discards any bit offered on the same edge.
      state_n  = IDLE;
      win_n    = '0;
      shadow_n = '0;
      cnt_n    = '0;
      par_n    = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;
      dout_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (DIN_VALID) begin
            win_n = win_shift;
            if (win_shift == PREAMBLE) begin
              state_n = LOAD;
              win_n   = '0;
              cnt_n   = '0;
              par_n   = 1'b0;
            end
          end
        end
        LOAD: begin
          if (DIN_VALID) begin
            shadow_n = {shadow[CFG_W-2:0], DIN};
            par_n    = par ^ DIN;
            cnt_n    = cnt + 6'd1;
            if (cnt >= LAST_BIT) begin
              state_n = PARITY;
            end
          end
        end
        PARITY: begin
          if (DIN_VALID) begin
            if (DIN == par) begin
              cfg_n       = shadow;
              cfg_valid_n = 1'b1;
              done_n      = 1'b1;
              state_n     = PASS;
            end else begin
              err_n   = 1'b1;
              state_n = ERROR;
            end
          end
        end
        PASS: begin
          dout_valid_n = DIN_VALID;
          if (DIN_VALID) begin
            dout_n = DIN;
          end
        end
        ERROR: begin
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Randomized self-checking bench for clb_cfg_loader: frames are built
// from the field rules and expected outputs derived from them.
module tb_clb_cfg_loader;

  localparam logic [36:0] DEF = {
    2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
    16'h0116, 2'b00, 6'b000111, 2'b00, 1'b0
  };

  logic        K;
  logic        rst_n;
  logic        PROG;
  logic        DIN;
  logic        DIN_VALID;
  logic [36:0] CFG;
  logic        CFG_VALID;
  logic        DONE;
  logic        ERR;
  logic        DOUT;
  logic        DOUT_VALID;

  int errors;
  int checks;
  int cv_count;
  logic [36:0] exp_cfg;

  clb_cfg_loader dut (
    .K          (K),
    .rst_n      (rst_n),
    .PROG       (PROG),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .CFG        (CFG),
    .CFG_VALID  (CFG_VALID),
    .DONE       (DONE),
    .ERR        (ERR),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID)
  );

  initial K = 1'b0;
  always #5 K = ~K;

  function automatic logic [41:0] mk_frame(
    input logic [36:0] d, input logic good);
    logic p;
    p = ^d;
    if (!good) p = ~p;
    return {4'b0010, d, p};
  endfunction

  function automatic logic [36:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[36:0];
  endfunction

  task automatic drive(input logic b, input logic v, input logic p);
    DIN = b;
    DIN_VALID = v;
    PROG = p;
    @(posedge K);
    #1;
    if (CFG_VALID) cv_count++;
  endtask

  // gap: 0 none, 1 idle every other cycle, 2 random idle bursts
  task automatic send_bits(input logic [41:0] f, input int hi,
                           input int lo, input int gap);
    for (int i = hi; i >= lo; i--) begin
      if (gap == 1) drive(1'($urandom()), 1'b0, 1'b0);
      if (gap == 2 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3))
          drive(1'($urandom()), 1'b0, 1'b0);
      drive(f[i], 1'b1, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
    @(posedge K);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0);
    pulse_reset();
    if (CFG !== DEF) begin
      errors++; $display("FAIL rst_cfg: got %h want %h", CFG, DEF);
    end
    checks++;
    release_reset();
    if (CFG !== DEF) begin
      errors++; $display("FAIL rst_cfg_rel: got %h want %h", CFG, DEF);
    end
    checks++;
    if (DONE !== 1'b0 || ERR !== 1'b0 || CFG_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: done=%b err=%b cv=%b want 000",
               DONE, ERR, CFG_VALID);
    end
    checks++;
    if (DOUT !== 1'b1 || DOUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_dout: dout=%b dv=%b want 1 0", DOUT, DOUT_VALID);
    end
    checks++;
    exp_cfg = DEF;
  endtask

  task automatic test_zero_frame();
    logic [41:0] f;
    f = mk_frame(37'd0, 1'b1);
    send_bits(f, 41, 1, 0);
    if (CFG_VALID !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL zero_early: cv=%b done=%b want 0 0", CFG_VALID, DONE);
    end
    checks++;
    drive(f[0], 1'b1, 1'b0);
    if (CFG_VALID !== 1'b1 || CFG !== 37'd0 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL zero_commit: cv=%b cfg=%h done=%b want 1 0 1",
               CFG_VALID, CFG, DONE);
    end
    checks++;
    drive(1'b0, 1'b0, 1'b0);
    if (CFG_VALID !== 1'b0) begin
      errors++; $display("FAIL zero_pulse: cv=%b want 0", CFG_VALID);
    end
    checks++;
    exp_cfg = 37'd0;
    drive(1'b0, 1'b0, 1'b1);
    if (DONE !== 1'b0 || CFG !== exp_cfg) begin
      errors++;
      $display("FAIL zero_prog: done=%b cfg=%h want 0 %h",
               DONE, CFG, exp_cfg);
    end
    checks++;
  endtask

  task automatic test_bad_parity_gapped();
    logic [41:0] f;
    logic [36:0] d;
    int cv0;
    pulse_reset();
    release_reset();
    exp_cfg = DEF;
    d = 37'h0;
    d[26:11] = 16'h8001;
    f = mk_frame(d, 1'b0);
    cv0 = cv_count;
    send_bits(f, 41, 0, 1);
    if (ERR !== 1'b1 || DONE !== 1'b0) begin
      errors++; $display("FAIL bad_err: err=%b done=%b want 1 0", ERR, DONE);
    end
    checks++;
    if (CFG !== DEF || cv_count != cv0) begin
      errors++;
      $display("FAIL bad_cfg: cfg=%h pulses=%0d want %h 0",
               CFG, cv_count - cv0, DEF);
    end
    checks++;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    if (ERR !== 1'b1 || DOUT_VALID !== 1'b0 || DOUT !== 1'b1) begin
      errors++;
      $display("FAIL bad_hold: err=%b dv=%b dout=%b want 1 0 1",
               ERR, DOUT_VALID, DOUT);
    end
    checks++;
    drive(1'b0, 1'b0, 1'b1);
    if (ERR !== 1'b0) begin
      errors++; $display("FAIL bad_prog: err=%b want 0", ERR);
    end
    checks++;
  endtask

  task automatic test_false_start_daisy();
    logic [41:0] f;
    logic [36:0] d;
    logic [4:0]  tail;
    d = rand_data();
    f = mk_frame(d, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    send_bits(f, 41, 0, 0);
    exp_cfg = d;
    if (CFG !== d || DONE !== 1'b1 || CFG_VALID !== 1'b1) begin
      errors++;
      $display("FAIL fs_cfg: cfg=%h done=%b cv=%b want %h 1 1",
               CFG, DONE, CFG_VALID, d);
    end
    checks++;
    tail = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      drive(tail[i], 1'b1, 1'b0);
      if (DOUT !== tail[i] || DOUT_VALID !== 1'b1) begin
        errors++;
        $display("FAIL daisy_bit%0d: dout=%b dv=%b want %b 1",
                 4 - i, DOUT, DOUT_VALID, tail[i]);
      end
      checks++;
      if (i == 2) begin
        drive(1'b0, 1'b0, 1'b0);
        if (DOUT_VALID !== 1'b0) begin
          errors++; $display("FAIL daisy_gap: dv=%b want 0", DOUT_VALID);
        end
        checks++;
      end
    end
  endtask

  task automatic test_abort();
    logic [41:0] f;
    logic [41:0] g;
    logic [36:0] a;
    logic [36:0] b;
    int cv0;
    drive(1'b0, 1'b0, 1'b1);
    f = mk_frame(rand_data(), 1'b1);
    send_bits(f, 41, 18, 0);
    pulse_reset();
    if (CFG !== DEF || DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: cfg=%h done=%b want %h 0", CFG, DONE, DEF);
    end
    checks++;
    release_reset();
    cv0 = cv_count;
    send_bits(f, 17, 0, 0);
    if (cv_count != cv0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst_tail: pulses=%0d done=%b want 0 0",
               cv_count - cv0, DONE);
    end
    checks++;
    drive(1'b0, 1'b0, 1'b1);
    a = rand_data();
    send_bits(mk_frame(a, 1'b1), 41, 0, 2);
    if (CFG !== a) begin
      errors++; $display("FAIL abort_a: cfg=%h want %h", CFG, a);
    end
    checks++;
    drive(1'b0, 1'b0, 1'b1);
    b = rand_data();
    g = mk_frame(b, 1'b1);
    send_bits(g, 41, 18, 0);
    drive(1'b0, 1'b0, 1'b1);
    if (CFG !== a || DONE !== 1'b0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL abort_prog: cfg=%h done=%b err=%b want %h 0 0",
               CFG, DONE, ERR, a);
    end
    checks++;
    send_bits(g, 41, 0, 0);
    exp_cfg = b;
    if (CFG !== b || DONE !== 1'b1) begin
      errors++;
      $display("FAIL abort_b: cfg=%h done=%b want %h 1", CFG, DONE, b);
    end
    checks++;
  endtask

  task automatic test_prog_collision();
    logic [36:0] c;
    int cv0;
    drive(1'b1, 1'b1, 1'b1);
    if (DOUT_VALID !== 1'b0 || DOUT !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL coll_prog: dv=%b dout=%b done=%b want 0 1 0",
               DOUT_VALID, DOUT, DONE);
    end
    checks++;
    c = rand_data();
    cv0 = cv_count;
    send_bits(mk_frame(c, 1'b1), 41, 0, 0);
    drive(1'b0, 1'b0, 1'b0);
    exp_cfg = c;
    if (CFG !== c || cv_count != cv0 + 1) begin
      errors++;
      $display("FAIL coll_reload: cfg=%h pulses=%0d want %h 1",
               CFG, cv_count - cv0, c);
    end
    checks++;
  endtask

  task automatic test_random_frames();
    logic [36:0] d;
    logic good;
    int cv0;
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b0, 1'b1);
      d = rand_data();
      good = 1'($urandom());
      cv0 = cv_count;
      send_bits(mk_frame(d, good), 41, 0, 2);
      drive(1'b0, 1'b0, 1'b0);
      if (good) exp_cfg = d;
      if (CFG !== exp_cfg) begin
        errors++;
        $display("FAIL rnd%0d_cfg: got %h want %h", n, CFG, exp_cfg);
      end
      checks++;
      if (DONE !== good || ERR !== !good ||
          cv_count != cv0 + int'(good)) begin
        errors++;
        $display("FAIL rnd%0d_flags: done=%b err=%b pulses=%0d good=%b",
                 n, DONE, ERR, cv_count - cv0, good);
      end
      checks++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cv_count = 0;
    exp_cfg = DEF;
    rst_n = 1'b1;
    PROG = 1'b0;
    DIN = 1'b0;
    DIN_VALID = 1'b0;
    test_reset();
    test_zero_frame();
    test_bad_parity_gapped();
    test_false_start_daisy();
    test_abort();
    test_prog_collision();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clb_cfg_loader.md
# clb_cfg_loader

Serial configuration loader that sits directly upstream of the 4-input CLB. It accepts a framed, bit-serial configuration stream, checks the preamble and parity, and presents the CLB's complete 37-bit configuration word:

- mux selects
- 16-bit LUT memory
- combine option
- input-steering bits
- DQ muxes
- flop/latch select

Once its own frame is committed, it forwards all further stream bits to the next loader in a daisy chain.

## Interface
Parameters:
- CFG_W, 37: configuration word width. Fixed by the CLB field map; not to be overridden.
- PREAMBLE, 4'b0010: frame start pattern.

Ports:
- K  in  1: clock. All state updates on rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- PROG  in  1: synchronous restart request, one-cycle pulse.
- DIN  in  1: serial configuration bit.
- DIN_VALID  in  1: DIN is sampled on this edge.
- CFG  out  CFG_W: committed configuration word.
- CFG_VALID  out  1: one-cycle pulse when CFG is updated.
- DONE  out  1: own frame committed; pass-through active.
- ERR  out  1: sticky parity error.
- DOUT  out  1: daisy-chain serial out.
- DOUT_VALID  out  1: DOUT qualifier.

## Operation
CFG field map, MSB first:

- [36:35] mux2select
- [34:33] mux3select
- [32:31] mux4select
- [30:29] mux5select
- [28:27] mux6select
- [26:11] mem[15:0]
- [10:9] comboption
- [8:3] o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
- [2:1] DQmux1, DQmux2
- [0] floporlatch

CFG reset/default value:

- mux2/3/4 selects = 2'b10
- mux5/6 selects = 2'b00
- mem = 16'h0116
- comboption = 2'b00
- o2m bits = 6'b000111
- DQmux bits = 2'b00
- floporlatch = 0

Frame format: PREAMBLE (4 bits), then 37 data bits MSB first, then 1 parity bit. The frame is 42 bits total. Only beats with DIN_VALID=1 count; idle gaps of any length are allowed anywhere in the frame.

State machine:

- **IDLE**
  - A 4-bit window shifts in accepted bits.
  - When the window equals PREAMBLE (including the bit accepted this edge), go to LOAD and clear the bit counter.
  - Overlapping false starts are allowed; 0011_0010 matches only at the final 0.
- **LOAD**
  - Shift accepted bits into a shadow register and increment the counter.
  - After the 37th data bit, go to PARITY.
- **PARITY**
  - Accept one bit.
  - If it equals the XOR of all 37 data bits:
    - copy shadow to CFG;
    - pulse CFG_VALID;
    - set DONE;
    - go to PASS.
  - Otherwise set ERR, go to ERROR, and leave CFG unchanged.
- **PASS**
  - On each accepted DIN: DOUT <= DIN and DOUT_VALID <= 1. Otherwise DOUT_VALID <= 0.
  - Remains in PASS until PROG or reset.
- **ERROR**
  - Ignores DIN. DOUT_VALID = 0.
  - Held until PROG or reset.

PROG, from any state:

- Next state IDLE.
- DONE, ERR, counter, window and shadow all cleared.
- CFG keeps its last committed value.
- PROG wins over a simultaneous DIN_VALID; that bit is discarded.

Outside PASS: DOUT = 1 and DOUT_VALID = 0.

## Timing
Reset (asynchronous, rst_n=0):

- state IDLE
- CFG = default
- CFG_VALID = 0, DONE = 0, ERR = 0
- DOUT = 1, DOUT_VALID = 0

Reset mid-frame aborts the load; a fresh preamble is required.

Per-edge timing:

- One accepted bit per K edge at most.
- The state transition takes effect on the edge that accepts the triggering bit.
- CFG, CFG_VALID and DONE change on the edge that accepts a correct parity bit, so they are visible in the following cycle.
- CFG_VALID is high for exactly one cycle.
- ERR asserts on the edge that accepts a bad parity bit.
- Pass-through latency is 1 cycle (registered). The first bit after parity is forwarded.
- All outputs are registered; there are no combinational paths from DIN.
- The counter is 6 bits and never wraps within a frame. A counter value above 36 is unreachable and treated as a PARITY transition.

## Structure
- Package clb_cfg_pkg holds:
  - CFG_W and PREAMBLE;
  - field offset/width localparams for each field in the map;
  - CFG_DEFAULT;
  - the state enum (IDLE, LOAD, PARITY, PASS, ERROR).
- The CLB wrapper uses the same package to unpack CFG.
- No sub-module: a single module with the FSM, shadow register, parity accumulator and counter.

## Test plan
- **Reset values:** assert rst_n=0 mid-cycle, then release. Required: CFG = default (mem=16'h0116, o2m=6'b000111, mux2/3/4=2'b10), DONE=0, ERR=0, DOUT=1.
- **All-zero frame:** 0010, 37×0, parity 0, DIN_VALID held high. Required: CFG=0 and CFG_VALID pulses one cycle after the 42nd bit; DONE=1.
- **Gapped frame with bad parity:** frame with mem=16'h8001, other fields 0, parity=1, and DIN_VALID low every other cycle. Required: ERR=1 after the parity bit; CFG still default; CFG_VALID never pulses.
- **False start and daisy chain:**
  - Send 0011_0010, a valid frame, then 10110.
  - Required: the frame is recognised at the final 0 only.
  - Required: after DONE, DOUT reproduces 1,0,1,1,0, each one cycle later with DOUT_VALID=1.
- **Mid-frame abort:**
  - Assert rst_n=0 after 20 data bits. Required: IDLE, CFG default.
  - Repeat with PROG after 20 data bits. Required: IDLE, CFG retains the previous commit, ERR/DONE cleared.
- **PROG collision:** PROG coincident with DIN_VALID in PASS. Required: no DOUT_VALID; the next preamble loads a new CFG.
